// File: rtl/dmem_unit_if.sv
// Processor-to-data-memory bus: address, size controls, store data, load data and debug status.
// The master side is the processor datapath; the slave side is dmem_unit.
interface dmem_unit_if;
   logic [0:31] addr_to_mem;
   logic        write_enable_to_mem;
   logic        byte_to_mem;
   logic        half_word_to_mem;
   logic        sign_extend_to_mem;
   logic [0:31] data_to_mem;
   logic [0:31] data_from_mem;
   logic        misaligned;
   logic        out_of_range;
   logic [0:31] fault_addr;
   logic [15:0] store_count;

   modport master (
      output addr_to_mem, write_enable_to_mem, byte_to_mem, half_word_to_mem,
             sign_extend_to_mem, data_to_mem,
      input  data_from_mem, misaligned, out_of_range, fault_addr, store_count
   );

   modport slave (
      input  addr_to_mem, write_enable_to_mem, byte_to_mem, half_word_to_mem,
             sign_extend_to_mem, data_to_mem,
      output data_from_mem, misaligned, out_of_range, fault_addr, store_count
   );
endinterface

// File: rtl/dmem_unit.sv
// Big-endian byte-addressed data memory: combinational loads, clocked stores, sticky fault flags.
// Optional bounds checking on the upper address bits is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_unit #(
   parameter int ADDR_BITS = 12
) (
   input  logic       clock,
   input  logic       reset,
   dmem_unit_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_BITS;

`ifdef DMEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   logic [0:7]           mem [DEPTH];
   logic [ADDR_BITS-1:0] idx0, idx1, idx2, idx3;
   logic [0:7]           b0, b1, b2, b3;
   logic                 is_byte, is_half, is_word;
   logic                 upper_hit, mis_now, oor_now, fault_now, commit, fill;
   logic                 mis_q, oor_q;
   logic [0:31]          fault_addr_q;
   logic [15:0]          store_count_q;
   logic [0:31]          load_data;

   assign idx0 = bus.addr_to_mem[32-ADDR_BITS:31];
   assign idx1 = idx0 + ADDR_BITS'(1);
   assign idx2 = idx0 + ADDR_BITS'(2);
   assign idx3 = idx0 + ADDR_BITS'(3);

   assign b0 = mem[idx0];
   assign b1 = mem[idx1];
   assign b2 = mem[idx2];
   assign b3 = mem[idx3];

   assign is_byte = bus.byte_to_mem;
   assign is_half = !bus.byte_to_mem && bus.half_word_to_mem;
   assign is_word = !bus.byte_to_mem && !bus.half_word_to_mem;

   assign mis_now   = (is_half && bus.addr_to_mem[31]) ||
                      (is_word && (bus.addr_to_mem[30] || bus.addr_to_mem[31]));
   // Without bounds checking the upper bits simply alias onto the implemented range.
   assign upper_hit = |bus.addr_to_mem[0:31-ADDR_BITS];
   assign oor_now   = BOUNDS_EN && upper_hit;
   assign fault_now = mis_now || oor_now;
   assign commit    = bus.write_enable_to_mem && !reset && !fault_now;

   // The first fetched byte holds the sign bit for both byte and half loads.
   assign fill = bus.sign_extend_to_mem && b0[0];

   always_comb begin
      load_data = '0;
      if (!fault_now) begin
         if (is_byte) begin
            load_data = {{24{fill}}, b0};
         end else if (is_half) begin
            load_data = {{16{fill}}, b0, b1};
         end else begin
            load_data = {b0, b1, b2, b3};
         end
      end
   end

   // Memory contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (commit) begin
         if (is_byte) begin
            mem[idx0] <= bus.data_to_mem[24:31];
         end else if (is_half) begin
            mem[idx0] <= bus.data_to_mem[16:23];
            mem[idx1] <= bus.data_to_mem[24:31];
         end else begin
            mem[idx0] <= bus.data_to_mem[0:7];
            mem[idx1] <= bus.data_to_mem[8:15];
            mem[idx2] <= bus.data_to_mem[16:23];
            mem[idx3] <= bus.data_to_mem[24:31];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mis_q         <= 1'b0;
         oor_q         <= 1'b0;
         fault_addr_q  <= '0;
         store_count_q <= '0;
      end else begin
         if (fault_now) begin
            if (!mis_q && !oor_q) begin
               fault_addr_q <= bus.addr_to_mem;
            end
            mis_q <= mis_q || mis_now;
            oor_q <= oor_q || oor_now;
         end
         if (commit) begin
            store_count_q <= store_count_q + 16'd1;
         end
      end
   end

   assign bus.data_from_mem = load_data;
   assign bus.misaligned    = mis_q;
   assign bus.out_of_range  = oor_q;
   assign bus.fault_addr    = fault_addr_q;
   assign bus.store_count   = store_count_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: directed cases followed by random accesses against a byte-array model.
// Follows DMEM_BOUNDS_CHECK_EN so the same bench covers both build configurations.
module tb_dmem_unit;
   localparam int AB    = 12;
   localparam int MEMSZ = 1 << AB;

`ifdef DMEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   dmem_unit_if bus ();

   dmem_unit #(.ADDR_BITS(AB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          id;
      bit          chk_data;
      bit          chk_state;
      logic [31:0] data;
      bit          mis;
      bit          oor;
      logic [31:0] fa;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sbq [$];
   logic [7:0]  m_mem   [MEMSZ];
   bit          m_valid [MEMSZ];
   bit          m_mis, m_oor, m_state_known;
   logic [31:0] m_fa;
   logic [15:0] m_cnt;
   int          vec_id;
   int          vectors;
   int          miscompares;

   initial begin
      for (int i = 0; i < MEMSZ; i++) begin
         m_valid[i] = 1'b0;
         m_mem[i]   = 8'h00;
      end
      m_state_known = 1'b0;
      m_mis = 1'b0;
      m_oor = 1'b0;
      m_fa  = '0;
      m_cnt = '0;
      vec_id      = 0;
      vectors     = 0;
      miscompares = 0;
   end

   function automatic int access_bytes(input bit bsel, input bit hsel);
      return bsel ? 1 : (hsel ? 2 : 4);
   endfunction

   function automatic bit is_misaligned(input logic [31:0] addr, input int n);
      return (addr % n) != 0;
   endfunction

   function automatic bit is_oor(input logic [31:0] addr);
      return BOUNDS && ((addr >> AB) != 0);
   endfunction

   // Model load: gathers bytes big-endian with plain arithmetic; known=0 if any byte never written.
   function automatic logic [31:0] model_load(input logic [31:0] addr, input bit bsel,
                                              input bit hsel, input bit sx, output bit known);
      int          n;
      int          base;
      logic [31:0] val;
      n     = access_bytes(bsel, hsel);
      known = 1'b1;
      if (is_misaligned(addr, n) || is_oor(addr)) return 32'h0;
      base = int'(addr % MEMSZ);
      val  = 32'h0;
      for (int i = 0; i < n; i++) begin
         val = val * 256 + 32'(m_mem[(base + i) % MEMSZ]);
         if (!m_valid[(base + i) % MEMSZ]) known = 1'b0;
      end
      if (sx && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8*n)) - 32'h1);
      return val;
   endfunction

   task automatic model_edge(input logic [31:0] addr, input bit we, input bit bsel,
                             input bit hsel, input logic [31:0] wdata, input bit rst);
      int n;
      int base;
      bit mis;
      bit oor;
      if (rst) begin
         m_mis = 1'b0;
         m_oor = 1'b0;
         m_fa  = '0;
         m_cnt = '0;
         m_state_known = 1'b1;
         return;
      end
      n   = access_bytes(bsel, hsel);
      mis = is_misaligned(addr, n);
      oor = is_oor(addr);
      if (mis || oor) begin
         if (!m_mis && !m_oor) m_fa = addr;
         m_mis = m_mis || mis;
         m_oor = m_oor || oor;
      end else if (we) begin
         base = int'(addr % MEMSZ);
         for (int i = 0; i < n; i++) begin
            m_mem[(base + i) % MEMSZ]   = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
            m_valid[(base + i) % MEMSZ] = 1'b1;
         end
         m_cnt = m_cnt + 16'd1;
      end
   endtask

   // Drives one cycle of bus activity, queues the expected response, then advances the model.
   task automatic applyStimulus(input logic [31:0] addr, input bit we, input bit bsel,
                                input bit hsel, input bit sx, input logic [31:0] wdata,
                                input bit rst);
      exp_t e;
      bit   known;
      @(posedge clock);
      #1;
      reset                   = rst;
      bus.addr_to_mem         = addr;
      bus.write_enable_to_mem = we;
      bus.byte_to_mem         = bsel;
      bus.half_word_to_mem    = hsel;
      bus.sign_extend_to_mem  = sx;
      bus.data_to_mem         = wdata;
      e.id        = vec_id;
      e.data      = model_load(addr, bsel, hsel, sx, known);
      e.chk_data  = known;
      e.chk_state = m_state_known;
      e.mis       = m_mis;
      e.oor       = m_oor;
      e.fa        = m_fa;
      e.cnt       = m_cnt;
      sbq.push_back(e);
      vec_id++;
      model_edge(addr, we, bsel, hsel, wdata, rst);
   endtask

   task automatic checkOutput(input string name, input int id, input logic [31:0] act,
                              input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("[TB] FAIL %s vec %0d: got %h expected %h", name, id, act, want);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.chk_data) checkOutput("load_data", e.id, bus.data_from_mem, e.data);
         if (e.chk_state) begin
            checkOutput("misaligned", e.id, 32'(bus.misaligned), 32'(e.mis));
            checkOutput("out_of_range", e.id, 32'(bus.out_of_range), 32'(e.oor));
            checkOutput("fault_addr", e.id, bus.fault_addr, e.fa);
            checkOutput("store_count", e.id, 32'(bus.store_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      logic [31:0] addr;
      bit          drained;
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // Zero the low window so later loads have known contents.
      for (int a = 0; a < 256; a += 4) applyStimulus(32'(a), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      applyStimulus(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11223344, 1'b0);
      applyStimulus(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h13, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      applyStimulus(32'h21, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000000F0, 1'b0);
      applyStimulus(32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h21, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
      applyStimulus(32'h21, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      applyStimulus(32'h32, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00008001, 1'b0);
      applyStimulus(32'h32, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
      applyStimulus(32'h32, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      applyStimulus(32'h41, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
      applyStimulus(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h43, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      applyStimulus(32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0);
      applyStimulus(32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1);
      applyStimulus(32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      applyStimulus(32'h00001000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55667788, 1'b0);
      applyStimulus(32'h00001000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         addr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFFF000);
         applyStimulus(addr, $urandom_range(0, 9) < 4, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                       $urandom_range(0, 59) == 0);
      end

      drained = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock);
         if (sbq.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      if (!drained) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
